// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the RV32I memory-side blocks.
package rv32i_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 32;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Byte lanes touched by an access of size sz at byte offset off within a word.
    function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [1:0] off, input mem_size_e sz);
        case (sz)
            MEM_B:   return WORD_BYTES'(4'b0001 << off);
            MEM_H:   return off[1] ? 4'b1100 : 4'b0011;
            MEM_W:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-aligned store data copied into every lane so the mask alone picks the target.
    function automatic logic [WORD_W-1:0] lane_replicate(input logic [WORD_W-1:0] wd, input mem_size_e sz);
        case (sz)
            MEM_B:   return {4{wd[7:0]}};
            MEM_H:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_load_align.sv
// Extracts the addressed byte/half/word from a read word and sign- or zero-extends it.
module load_align
    import rv32i_mem_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        byte_off_i,
    input  mem_size_e         size_i,
    input  logic              unsigned_i,
    output logic [WORD_W-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{byte_off_i, 3'b000} +: 8];
    assign half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_c = '0;
        case (size_i)
            MEM_B:   data_c = unsigned_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            MEM_H:   data_c = unsigned_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            MEM_W:   data_c = word_i;
            default: data_c = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM serving one load/store at a time over valid/ready
// request and response channels, with fixed latency and error reporting.
module data_mem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned   IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned   CNT_W    = 3;
    localparam logic [32:0]   END_ADDR = 33'(BASE_ADDR) + 33'(DEPTH_WORDS * WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    logic [WORD_W-1:0] ram [DEPTH_WORDS];

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [WORD_W-1:0] res_q, res_d;
    logic              err_q, err_d;

    mem_size_e         size_c;
    logic [31:0]       off_c;
    logic [IDX_W-1:0]  idx_c;
    logic              range_err_c;
    logic              size_err_c;
    logic              misalign_c;
    logic              err_c;
    logic              accept_c;
    logic              wr_en_c;
    logic [WORD_BYTES-1:0] be_c;
    logic [WORD_W-1:0] wdata_rep_c;
    logic [WORD_W-1:0] rd_word_c;
    logic [WORD_W-1:0] align_c;
    logic [WORD_W-1:0] result_c;

    // Request decode, all evaluated against the live request at acceptance.
    assign size_c      = mem_size_e'(req_size);
    assign off_c       = req_addr - BASE_ADDR;
    assign idx_c       = IDX_W'(off_c >> 2);
    assign range_err_c = (req_addr < BASE_ADDR) || (33'(req_addr) >= END_ADDR);
    assign size_err_c  = (req_size == 2'b11);
    assign misalign_c  = ((size_c == MEM_H) && req_addr[0]) ||
                         ((size_c == MEM_W) && (req_addr[1:0] != 2'b00));
    assign err_c       = range_err_c || size_err_c || misalign_c;

    assign accept_c    = (state_q == IDLE) && req_ready_q && req_valid;
    assign wr_en_c     = accept_c && req_we && !err_c;
    assign be_c        = lane_mask(req_addr[1:0], size_c);
    assign wdata_rep_c = lane_replicate(req_wdata, size_c);
    assign rd_word_c   = ram[idx_c];

    load_align u_load_align (
        .word_i     (rd_word_c),
        .byte_off_i (req_addr[1:0]),
        .size_i     (size_c),
        .unsigned_i (req_unsigned),
        .data_c     (align_c)
    );

    assign result_c = (err_c || req_we) ? '0 : align_c;

    // Storage is deliberately left out of reset; a committed store survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < int'(WORD_BYTES); i++) begin
                if (be_c[i]) begin
                    ram[idx_c][i*8 +: 8] <= wdata_rep_c[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        err_d       = err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    res_d = result_c;
                    err_d = err_c;
                    cnt_d = CNT_INIT;
                    if (READ_LATENCY == 1) begin
                        state_d     = RESP;
                        rsp_rdata_d = result_c;
                        rsp_err_d   = err_c;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = RESP;
                    rsp_rdata_d = res_q;
                    rsp_err_d   = err_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs track the next state so they are valid as flops.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            res_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            res_q       <= res_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench: two responders (latency 1 and 3) driven in lockstep against a byte-array model.
module tb_data_mem_responder;

    localparam logic [31:0] BASE      = 32'h0000_1000;
    localparam int          MEM_BYTES = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic        req_ready3, rsp_valid3, rsp_err3;
    logic [31:0] rsp_rdata3;

    int n_vec;
    int n_err;

    logic [7:0] mdl [MEM_BYTES];

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(BASE), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(BASE), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready3), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
               (a < BASE) || (a >= BASE + 32'(MEM_BYTES));
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int off = int'(a - BASE);
        int n   = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[off + i];
        if (!uns && n < 4 && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic void mdl_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int off = int'(a - BASE);
        int n   = 1 << sz;
        for (int i = 0; i < n; i++) mdl[off + i] = wd[8*i +: 8];
    endfunction

    // One transaction on both DUTs; bp = extra cycles of response backpressure.
    task automatic txn(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd, input int bp, input string tag);
        logic        exp_err;
        logic [31:0] exp_d;
        int          t;
        int          k;
        int          lat1;
        int          lat3;

        exp_err = mdl_err(a, sz);
        exp_d   = (we || exp_err) ? 32'h0 : mdl_load(a, sz, uns);
        if (we && !exp_err) mdl_store(a, sz, wd);

        t = 0;
        while (!(req_ready1 && req_ready3) && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk({tag, "_rdy"}, {31'b0, req_ready1 & req_ready3}, 32'd1);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_unsigned = uns; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk({tag, "_busy"}, {30'b0, req_ready1, req_ready3}, 32'd0);

        k = 1; lat1 = 0; lat3 = 0;
        while ((lat1 == 0 || lat3 == 0) && k <= 20) begin
            if (lat1 == 0 && rsp_valid1) lat1 = k;
            if (lat3 == 0 && rsp_valid3) lat3 = k;
            if (lat1 == 0 || lat3 == 0) begin
                @(posedge clk); #1; k++;
            end
        end
        chk({tag, "_lat1"}, 32'(lat1), 32'd1);
        chk({tag, "_lat3"}, 32'(lat3), 32'd3);
        chk({tag, "_d1"}, rsp_rdata1, exp_d);
        chk({tag, "_e1"}, {31'b0, rsp_err1}, {31'b0, exp_err});
        chk({tag, "_d3"}, rsp_rdata3, exp_d);
        chk({tag, "_e3"}, {31'b0, rsp_err3}, {31'b0, exp_err});

        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {28'b0, rsp_valid1, rsp_valid3, req_ready1, req_ready3}, 32'hC);
            chk({tag, "_hd1"}, rsp_rdata1, exp_d);
            chk({tag, "_hd3"}, rsp_rdata3, exp_d);
        end

        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_done"}, {28'b0, rsp_valid1, rsp_valid3, req_ready1, req_ready3}, 32'h3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        n_vec = 0; n_err = 0;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs", {28'b0, rsp_valid1, rsp_valid3, req_ready1, req_ready3}, 32'h0);
        chk("rst_d1", rsp_rdata1, 32'h0);
        chk("rst_d3", rsp_rdata3, 32'h0);
        chk("rst_e", {30'b0, rsp_err1, rsp_err3}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        txn(1'b1, 32'h1000, 2'd2, 1'b0, 32'hDEADBEEF, 0, "sw0");
        txn(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 0, "lw0");

        for (int w = 0; w < MEM_BYTES / 4; w++) begin
            txn(1'b1, BASE + 32'(4 * w), 2'd2, 1'b0, $urandom, 0, "fill");
        end

        txn(1'b1, 32'h1005, 2'd0, 1'b0, 32'h0000_0080, 0, "sb");
        txn(1'b0, 32'h1005, 2'd0, 1'b0, 32'h0, 0, "lb");
        txn(1'b0, 32'h1005, 2'd0, 1'b1, 32'h0, 0, "lbu");
        txn(1'b0, 32'h1004, 2'd2, 1'b0, 32'h0, 0, "lw4");
        txn(1'b1, 32'h1000, 2'd2, 1'b0, 32'h8001_1234, 0, "sw1");
        txn(1'b0, 32'h1002, 2'd1, 1'b0, 32'h0, 0, "lh");
        txn(1'b0, 32'h1002, 2'd1, 1'b1, 32'h0, 0, "lhu");
        txn(1'b0, 32'h1002, 2'd2, 1'b0, 32'h0, 0, "lw_mis");
        txn(1'b1, 32'h1001, 2'd1, 1'b0, 32'h0000_FFFF, 0, "sh_mis");
        txn(1'b0, 32'h0FFC, 2'd2, 1'b0, 32'h0, 0, "lw_low");
        txn(1'b0, 32'h1400, 2'd0, 1'b0, 32'h0, 0, "lb_high");
        txn(1'b1, 32'h1000, 2'd3, 1'b0, 32'h1111_1111, 0, "sz3");
        txn(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 0, "lw_chk");
        txn(1'b1, 32'h13FE, 2'd1, 1'b0, 32'h0000_A5C3, 0, "sh_top");
        txn(1'b0, 32'h13FC, 2'd2, 1'b0, 32'h0, 5, "lw_bp");

        for (int i = 0; i < 400; i++) begin
            sz = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 99));
            if (r < 80) begin
                a = BASE + 32'($urandom_range(0, MEM_BYTES - 1));
                if (r < 55 && sz != 2'd3) a = a & ~(32'(1 << sz) - 32'd1);
            end else if (r < 92) begin
                a = BASE - 32'd8 + 32'($urandom_range(0, 7));
                if (r >= 86) a = BASE + 32'(MEM_BYTES) - 32'd4 + 32'($urandom_range(0, 7));
            end else begin
                a = $urandom;
            end
            txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
                int'($urandom_range(0, 3)), "rnd");
        end

        // Reset while the latency-3 instance sits in WAIT with a store already accepted.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1010; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h0000_005A;
        mdl_store(32'h1010, 2'd0, 32'h0000_005A);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_rst", {30'b0, rsp_valid1, rsp_valid3}, 32'h2);
        rst = 1'b0;
        #1;
        chk("mid_rst", {28'b0, rsp_valid1, rsp_valid3, req_ready1, req_ready3}, 32'h0);
        chk("mid_rst_d1", rsp_rdata1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_nv", {30'b0, rsp_valid1, rsp_valid3}, 32'h0);
        end
        chk("post_rst_rdy", {30'b0, req_ready1, req_ready3}, 32'h3);
        txn(1'b0, 32'h1010, 2'd0, 1'b1, 32'h0, 0, "lbu_rst");
        txn(1'b0, 32'h1010, 2'd2, 1'b0, 32'h0, 0, "lw_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the RV32I core's data-memory port: a word-organised synchronous RAM that serves the core's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Handles byte, half and word sizes, including sign and zero extension for loads, byte-lane writes for stores, and error reporting for misaligned or out-of-range accesses.
- Instantiated beside the instruction memory at the same top level. It is the data-side counterpart of the core's fetch path.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 4.
- BASE_ADDR, 32'h0000_1000, byte address of word 0; must be aligned to DEPTH_WORDS*4.
- READ_LATENCY, 1, cycles from request acceptance to rsp_valid; allowed range 1..4, applies to reads and writes.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserts immediately, releases synchronously to clk.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  access size as mem_size_e: 00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  input  1  for loads, 1 = zero-extend (LBU/LHU); ignored for stores and word loads.
- req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and on error.
- rsp_err  output  1  access was misaligned, out of range, or had an illegal size.

Behaviour:
- Reset (rst=0): state goes to IDLE, req_ready=0 while in reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE: req_ready=1. An edge with req_valid=1 is an acceptance. On acceptance, latch addr, size, unsigned and we, then load the counter with READ_LATENCY-1.
  - If READ_LATENCY=1, go directly to RESP.
  - Otherwise go to WAIT.
- WAIT: req_ready=0. Decrement the counter each edge; go to RESP when it reaches 0.
- RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready=1. On that edge go to IDLE. req_ready returns the following cycle, so there is no same-cycle request/response overlap.
- Latency: with READ_LATENCY=N, rsp_valid rises N edges after the acceptance edge. Minimum turnaround is N+1 cycles per transaction.
- Error check, evaluated at acceptance:
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Out of range: addr<BASE_ADDR or addr>=BASE_ADDR+DEPTH_WORDS*4.
  - Illegal size: req_size=11.
  - Any error gives rsp_err=1 and rsp_rdata=0. RAM is unchanged.
- Stores: RAM is written on the acceptance edge, with byte lanes selected by addr[1:0] and size; req_wdata is replicated into the selected lanes. Response has rsp_rdata=0 and rsp_err=0.
- Loads: the word is read at the acceptance address. The byte or half is selected by addr[1:0], then sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1). The result is registered into rsp_rdata when entering RESP.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Word index is (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; there is no address wrap-around.
- Reset mid-transaction returns the block to IDLE and drops any pending response. A store already accepted stays committed.
- req_valid while not in IDLE is ignored (no acceptance). Inputs are sampled only at acceptance.

Decomposition:
- Package rv32i_mem_pkg:
  - mem_size_e (MEM_B, MEM_H, MEM_W).
  - dmem_state_e (IDLE, WAIT, RESP).
  - Constant WORD_BYTES=4.
- Sub-module load_align: combinational. Takes the read word, addr[1:0], size and unsigned flag, and produces the 32-bit extended result. It is reused later by the core's writeback path.

Test Plan:
- Reset release, then SW 32'hDEADBEEF at 0x1000 followed by LW 0x1000 with READ_LATENCY=1 -> each rsp_valid appears 1 cycle after acceptance; load returns 32'hDEADBEEF, rsp_err=0.
- SB 8'h80 at 0x1005, then LB 0x1005 -> 32'hFFFFFF80; LBU 0x1005 -> 32'h00000080; LW 0x1004 -> bits [15:8]=8'h80, other bytes unchanged.
- LH 0x1002 after SW 32'h8001_1234 at 0x1000 -> 32'hFFFF8001; LHU 0x1002 -> 32'h00008001.
- Misaligned LW 0x1002, SH 0x1001, and LW 0x0FFC (out of range) -> rsp_err=1 and rsp_rdata=0; a following LW 0x1000 shows the word unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0; with READ_LATENCY=3, rsp_valid rises exactly 3 edges after acceptance.
- Drop rst to 0 while in WAIT -> rsp_valid=0 immediately; after release req_ready=1 and no response is emitted for the dropped request.
